// File: rtl/hazard_fwd_ctrl_if.sv
// Pipeline-side bundle for the hazard/forwarding controller. The stall counter
// port exists only when HAZ_STALL_CNT_EN is defined.
interface hazard_fwd_ctrl_if #(
    parameter int AW = 5
);
    logic [AW-1:0] id_rs_i;
    logic [AW-1:0] id_rt_i;
    logic          id_use_rt_i;
    logic [AW-1:0] ie_rs_i;
    logic [AW-1:0] ie_rt_i;
    logic [AW-1:0] ie_rd_i;
    logic          ie_memread_i;
    logic          ie_md_start_i;
    logic          em_regwrite_i;
    logic [AW-1:0] em_rd_i;
    logic          mw_regwrite_i;
    logic [AW-1:0] mw_rd_i;
    logic [1:0]    fwd_a_o;
    logic [1:0]    fwd_b_o;
    logic          fwd_id_a_o;
    logic          fwd_id_b_o;
    logic          stall_if_o;
    logic          stall_ex_o;
    logic          bubble_ex_o;
    logic          bubble_mem_o;
    logic          md_busy_o;
    logic          md_done_o;
`ifdef HAZ_STALL_CNT_EN
    logic [31:0]   stall_cnt_o;
`endif

    modport master (
        output id_rs_i, id_rt_i, id_use_rt_i, ie_rs_i, ie_rt_i, ie_rd_i,
        output ie_memread_i, ie_md_start_i, em_regwrite_i, em_rd_i,
        output mw_regwrite_i, mw_rd_i,
        input  fwd_a_o, fwd_b_o, fwd_id_a_o, fwd_id_b_o, stall_if_o,
        input  stall_ex_o, bubble_ex_o, bubble_mem_o, md_busy_o, md_done_o
`ifdef HAZ_STALL_CNT_EN
        , input stall_cnt_o
`endif
    );

    modport slave (
        input  id_rs_i, id_rt_i, id_use_rt_i, ie_rs_i, ie_rt_i, ie_rd_i,
        input  ie_memread_i, ie_md_start_i, em_regwrite_i, em_rd_i,
        input  mw_regwrite_i, mw_rd_i,
        output fwd_a_o, fwd_b_o, fwd_id_a_o, fwd_id_b_o, stall_if_o,
        output stall_ex_o, bubble_ex_o, bubble_mem_o, md_busy_o, md_done_o
`ifdef HAZ_STALL_CNT_EN
        , output stall_cnt_o
`endif
    );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: EX forwarding,
// WB->ID bypass, load-use and mul/div stalls. Optional stall counter: HAZ_STALL_CNT_EN.
module hazard_fwd_ctrl #(
    parameter int AW     = 5,
    parameter int MD_LAT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    hazard_fwd_ctrl_if.slave bus
);
    localparam int CW = $clog2(MD_LAT);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    md_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lu_s;
    logic          md_s;
    logic          stall_if_s;

    function automatic logic [1:0] ex_fwd_sel(
        input logic em_we, input logic [AW-1:0] em_rd,
        input logic mw_we, input logic [AW-1:0] mw_rd,
        input logic [AW-1:0] src
    );
        logic [1:0] sel;
        if (em_we && (em_rd != {AW{1'b0}}) && (em_rd == src)) begin
            sel = 2'b10;
        end else if (mw_we && (mw_rd != {AW{1'b0}}) && (mw_rd == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Forwarding and bypass selects, live regardless of stalls or reset
    always_comb begin
        bus.fwd_a_o    = ex_fwd_sel(bus.em_regwrite_i, bus.em_rd_i,
                                    bus.mw_regwrite_i, bus.mw_rd_i, bus.ie_rs_i);
        bus.fwd_b_o    = ex_fwd_sel(bus.em_regwrite_i, bus.em_rd_i,
                                    bus.mw_regwrite_i, bus.mw_rd_i, bus.ie_rt_i);
        bus.fwd_id_a_o = bus.mw_regwrite_i && (bus.mw_rd_i != {AW{1'b0}}) &&
                         (bus.mw_rd_i == bus.id_rs_i);
        bus.fwd_id_b_o = bus.mw_regwrite_i && (bus.mw_rd_i != {AW{1'b0}}) &&
                         (bus.mw_rd_i == bus.id_rt_i);
    end

    // Mul/div FSM next state; the final BUSY cycle ignores start because the
    // held instruction is still presenting it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        md_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.ie_md_start_i) begin
                    state_d = ST_BUSY;
                    cnt_d   = CW'(MD_LAT - 2);
                    md_s    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q != {CW{1'b0}}) begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                    md_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stall/bubble controls, all forced low during reset; md overrides load-use
    always_comb begin
        lu_s = bus.ie_memread_i && (bus.ie_rd_i != {AW{1'b0}}) &&
               ((bus.ie_rd_i == bus.id_rs_i) ||
                (bus.id_use_rt_i && (bus.ie_rd_i == bus.id_rt_i)));
        if (rst_i) begin
            stall_if_s       = 1'b0;
            bus.stall_ex_o   = 1'b0;
            bus.bubble_ex_o  = 1'b0;
            bus.bubble_mem_o = 1'b0;
            bus.md_busy_o    = 1'b0;
            bus.md_done_o    = 1'b0;
        end else begin
            stall_if_s       = lu_s || md_s;
            bus.stall_ex_o   = md_s;
            bus.bubble_ex_o  = lu_s && !md_s;
            bus.bubble_mem_o = md_s;
            bus.md_busy_o    = (state_q == ST_BUSY);
            bus.md_done_o    = (state_q == ST_BUSY) && (cnt_q == {CW{1'b0}});
        end
        bus.stall_if_o = stall_if_s;
    end

`ifdef HAZ_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of stalled cycles
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= 32'd0;
        end else if (stall_if_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    assign bus.stall_cnt_o = stall_cnt_q;
`endif
endmodule
